// File: rtl/ysyx_22040237_regfile.sv
// Integer register file x0..x31 for the ysyx_22040237 core.
// Two combinational read ports with write-back bypass, plus a per-register
// in-flight writer scoreboard used for read-after-write hazard detection.
// x0 has no storage: it always reads zero and is never busy.

`ifndef ysyx_22040237_REG_WIDTH
`define ysyx_22040237_REG_WIDTH 64
`endif

module ysyx_22040237_regfile #(
   parameter int SB_W = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wb_wr_en_i,
   input  logic [4:0]                            wb_idx_i,
   input  logic [`ysyx_22040237_REG_WIDTH-1:0]   wb_data_i,
   input  logic [4:0]                            rs1_idx_i,
   output logic [`ysyx_22040237_REG_WIDTH-1:0]   rs1_data_o,
   output logic                                  rs1_busy_o,
   input  logic [4:0]                            rs2_idx_i,
   output logic [`ysyx_22040237_REG_WIDTH-1:0]   rs2_data_o,
   output logic                                  rs2_busy_o,
   input  logic                                  iss_en_i,
   input  logic [4:0]                            iss_rd_idx_i,
   output logic                                  iss_ready_o,
   input  logic                                  flush_i,
   output logic [`ysyx_22040237_REG_WIDTH-1:0]   dbg_a0_o
);

   localparam int              XLEN    = `ysyx_22040237_REG_WIDTH;
   localparam logic [SB_W-1:0] CNT_MAX = '1;

   logic [XLEN-1:0] regs_q [1:31];
   logic [XLEN-1:0] regs_d [1:31];
   logic [SB_W-1:0] cnt_q  [1:31];
   logic [SB_W-1:0] cnt_d  [1:31];

   // Full 32-entry views with x0 pinned to zero, so index 0 needs no special case.
   logic [XLEN-1:0] regs_rd [0:31];
   logic [SB_W-1:0] cnt_rd  [0:31];
   logic [31:0]     dec_v;

   // Zero-extended storage views and the per-register retire (dec) strobes.
   always_comb begin
      regs_rd[0] = '0;
      cnt_rd[0]  = '0;
      dec_v      = '0;
      for (int r = 1; r < 32; r++) begin
         regs_rd[r] = regs_q[r];
         cnt_rd[r]  = cnt_q[r];
         dec_v[r]   = wb_wr_en_i && (wb_idx_i == 5'(r)) && (cnt_q[r] != '0);
      end
   end

   // Read port 1: zero for x0, then bypass from write-back, then storage.
   always_comb begin
      rs1_data_o = regs_rd[rs1_idx_i];
      if (rs1_idx_i == 5'd0) begin
         rs1_data_o = '0;
      end else if (wb_wr_en_i && (wb_idx_i == rs1_idx_i)) begin
         rs1_data_o = wb_data_i;
      end
   end

   // Read port 2: same resolution as port 1, independently.
   always_comb begin
      rs2_data_o = regs_rd[rs2_idx_i];
      if (rs2_idx_i == 5'd0) begin
         rs2_data_o = '0;
      end else if (wb_wr_en_i && (wb_idx_i == rs2_idx_i)) begin
         rs2_data_o = wb_data_i;
      end
   end

   // Busy looks through a write-back that retires the last pending writer now.
   always_comb begin
      rs1_busy_o = (rs1_idx_i != 5'd0) &&
                   ((cnt_rd[rs1_idx_i] - SB_W'(dec_v[rs1_idx_i])) != '0);
      rs2_busy_o = (rs2_idx_i != 5'd0) &&
                   ((cnt_rd[rs2_idx_i] - SB_W'(dec_v[rs2_idx_i])) != '0);
   end

   // Issue is refused only when the counter is saturated and nothing retires.
   always_comb begin
      iss_ready_o = (iss_rd_idx_i == 5'd0) ||
                    (cnt_rd[iss_rd_idx_i] != CNT_MAX) ||
                    dec_v[iss_rd_idx_i];
   end

   assign dbg_a0_o = regs_q[10];

   // Next-state for register data and scoreboard counters.
   always_comb begin
      for (int r = 1; r < 32; r++) begin
         regs_d[r] = regs_q[r];
         cnt_d[r]  = cnt_q[r];
         if (wb_wr_en_i && (wb_idx_i == 5'(r))) begin
            regs_d[r] = wb_data_i;
         end
         if (flush_i) begin
            cnt_d[r] = '0;
         end else if (iss_en_i && iss_ready_o && (iss_rd_idx_i == 5'(r))) begin
            if (!dec_v[r]) begin
               cnt_d[r] = cnt_q[r] + SB_W'(1);
            end
         end else if (dec_v[r]) begin
            cnt_d[r] = cnt_q[r] - SB_W'(1);
         end
      end
   end

   // State registers; asynchronous reset clears data and counts at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 1; r < 32; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         for (int r = 1; r < 32; r++) begin
            regs_q[r] <= regs_d[r];
            cnt_q[r]  <= cnt_d[r];
         end
      end
   end

endmodule
